// File: rtl/memlog.sv
// Capture buffer: records 2^BRAM_ADDR_WIDTH consecutive filter samples into a BRAM, then streams or random-reads them.
// Optional MEMLOG_STATUS_EN packs {state, mem_full} into the top three readback bits.
module memlog #(
  parameter int BRAM_ADDR_WIDTH = 15,
  parameter int BRAM_DATA_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       i_rst,
  input  logic [BRAM_DATA_WIDTH-1:0] i_filter_data,
  input  logic                       i_run_log,
  input  logic                       i_read_log,
  input  logic [BRAM_ADDR_WIDTH-1:0] i_addr_log_to_mem,
  output logic                       o_mem_full,
  output logic [31:0]                o_data_log_from_mem
);

  localparam int DEPTH = 1 << BRAM_ADDR_WIDTH;
  localparam logic [BRAM_ADDR_WIDTH-1:0] ONE  = {{(BRAM_ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [BRAM_ADDR_WIDTH-1:0] LAST = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FULL = 2'd2,
    READ = 2'd3
  } state_t;

  state_t                     state_q, state_d;
  logic [BRAM_ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [BRAM_ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic                       mem_full_q, mem_full_d;
  logic                       rd_en;
  logic                       wr_en;
  logic [BRAM_ADDR_WIDTH-1:0] rd_addr;
  logic [BRAM_DATA_WIDTH-1:0] rd_data_q;
  logic [BRAM_DATA_WIDTH-1:0] mem [DEPTH];

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    mem_full_d = mem_full_q;
    rd_en      = 1'b0;
    wr_en      = 1'b0;
    rd_addr    = i_addr_log_to_mem;
    case (state_q)
      IDLE, FULL: begin
        if (i_run_log) begin
          state_d    = RUN;
          wr_ptr_d   = '0;
          mem_full_d = 1'b0;
        end else if (i_read_log) begin
          // Word 0 is fetched on the request edge so streaming starts immediately.
          state_d  = READ;
          rd_en    = 1'b1;
          rd_addr  = '0;
          rd_ptr_d = ONE;
        end else begin
          rd_en = 1'b1;
        end
      end
      RUN: begin
        wr_en    = 1'b1;
        wr_ptr_d = wr_ptr_q + ONE;
        if (wr_ptr_q == LAST) begin
          state_d    = FULL;
          mem_full_d = 1'b1;
        end
      end
      READ: begin
        rd_en    = 1'b1;
        rd_addr  = rd_ptr_q;
        rd_ptr_d = rd_ptr_q + ONE;
        if (rd_ptr_q == LAST) begin
          state_d = mem_full_q ? FULL : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      mem_full_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      mem_full_q <= mem_full_d;
    end
  end

  // Write and read ports are never active together, so this maps to a simple dual-port BRAM.
  always_ff @(posedge clk) begin
    if (wr_en && !i_rst) begin
      mem[wr_ptr_q] <= i_filter_data;
    end
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      rd_data_q <= '0;
    end else if (rd_en) begin
      rd_data_q <= mem[rd_addr];
    end
  end

  assign o_mem_full = mem_full_q;

`ifdef MEMLOG_STATUS_EN
  logic [1:0] stat_state_q;
  logic       stat_full_q;

  // Status tracks the state entered on each edge, so it stays current even while data holds.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      stat_state_q <= 2'd0;
      stat_full_q  <= 1'b0;
    end else begin
      stat_state_q <= state_d;
      stat_full_q  <= mem_full_d;
    end
  end

  assign o_data_log_from_mem = {stat_state_q, stat_full_q, {(29-BRAM_DATA_WIDTH){1'b0}}, rd_data_q};
`else
  assign o_data_log_from_mem = {{(32-BRAM_DATA_WIDTH){1'b0}}, rd_data_q};
`endif

endmodule

// File: tb/tb_memlog.sv
`timescale 1ns/1ps
module tb_memlog;
  localparam int AW    = 15;
  localparam int DW    = 16;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          i_rst;
  logic [DW-1:0] i_filter_data;
  logic          i_run_log;
  logic          i_read_log;
  logic [AW-1:0] i_addr_log_to_mem;
  logic          o_mem_full;
  logic [31:0]   o_data_log_from_mem;

  always #10 clk = ~clk;

  memlog #(.BRAM_ADDR_WIDTH(AW), .BRAM_DATA_WIDTH(DW)) dut (
    .clk                 (clk),
    .i_rst               (i_rst),
    .i_filter_data       (i_filter_data),
    .i_run_log           (i_run_log),
    .i_read_log          (i_read_log),
    .i_addr_log_to_mem   (i_addr_log_to_mem),
    .o_mem_full          (o_mem_full),
    .o_data_log_from_mem (o_data_log_from_mem)
  );

  logic [DW-1:0] ref_mem [DEPTH];
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   exp_data;
    logic          exp_full;
  } vec_t;
  vec_t tbl [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ext(input logic [DW-1:0] w);
    return 32'(w);
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] w;
    logic [AW-1:0] a;

    tbl[0].addr = 15'd0;     tbl[1].addr = 15'd1;
    tbl[2].addr = 15'd1234;  tbl[3].addr = 15'd32767;
    tbl[4].addr = 15'd16384; tbl[5].addr = 15'd255;
    tbl[6].addr = 15'd4096;  tbl[7].addr = 15'd32766;

    i_rst = 1'b1; i_filter_data = '0; i_run_log = 1'b0; i_read_log = 1'b0; i_addr_log_to_mem = '0;
    @(negedge clk);
    chk("reset_full", 32'(o_mem_full), 32'd0);
    chk("reset_data", o_data_log_from_mem, 32'd0);
    i_rst = 1'b0;

    // Capture A with a stray read request in the middle.
    i_run_log = 1'b1;
    @(negedge clk);
    i_run_log = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      w = DW'($urandom);
      i_filter_data = w;
      ref_mem[k] = w;
      i_read_log = (k == 5000);
      @(negedge clk);
      chk("capture_full", 32'(o_mem_full), (k == DEPTH-1) ? 32'd1 : 32'd0);
    end
    i_read_log = 1'b0;

    for (int i = 0; i < 4; i++) begin
      a = AW'($urandom);
      i_addr_log_to_mem = a;
      @(negedge clk);
      chk("full_hold", 32'(o_mem_full), 32'd1);
      chk("rand_access", o_data_log_from_mem, ext(ref_mem[a]));
    end

    // Sequential readback with requests toggling (must be ignored).
    i_read_log = 1'b1;
    @(negedge clk);
    chk("readback_0", o_data_log_from_mem, ext(ref_mem[0]));
    for (int k = 1; k < DEPTH; k++) begin
      i_read_log = 1'($urandom_range(0, 1));
      i_addr_log_to_mem = AW'($urandom);
      @(negedge clk);
      chk("readback", o_data_log_from_mem, ext(ref_mem[k]));
    end
    i_read_log = 1'b0;
    i_addr_log_to_mem = 15'd1234;
    @(negedge clk);
    chk("after_read_full", 32'(o_mem_full), 32'd1);
    chk("after_read_1234", o_data_log_from_mem, ext(ref_mem[1234]));

    for (int i = 0; i < 8; i++) begin
      tbl[i].exp_data = ext(ref_mem[tbl[i].addr]);
      tbl[i].exp_full = 1'b1;
    end
    for (int i = 0; i < 8; i++) begin
      i_addr_log_to_mem = tbl[i].addr;
      @(negedge clk);
      chk("table_data", o_data_log_from_mem, tbl[i].exp_data);
      chk("table_full", 32'(o_mem_full), 32'(tbl[i].exp_full));
    end

    // Run and read together: run wins and full drops.
    i_run_log = 1'b1; i_read_log = 1'b1;
    @(negedge clk);
    chk("prio_full", 32'(o_mem_full), 32'd0);
    i_run_log = 1'b0; i_read_log = 1'b0;
    for (int k = 0; k <= 100; k++) begin
      w = DW'($urandom);
      i_filter_data = w;
      ref_mem[k] = w;
      @(negedge clk);
    end
    chk("partial_full", 32'(o_mem_full), 32'd0);
    i_rst = 1'b1;
    i_filter_data = DW'($urandom);
    @(negedge clk);
    i_rst = 1'b0;
    chk("midrun_rst_full", 32'(o_mem_full), 32'd0);
    chk("midrun_rst_data", o_data_log_from_mem, 32'd0);
    i_addr_log_to_mem = 15'd50;
    @(negedge clk);
    chk("idle_after_rst", o_data_log_from_mem, ext(ref_mem[50]));

    // Restart must write from address 0 again.
    i_run_log = 1'b1;
    @(negedge clk);
    i_run_log = 1'b0;
    for (int k = 0; k < 20; k++) begin
      w = DW'($urandom);
      i_filter_data = w;
      ref_mem[k] = w;
      @(negedge clk);
    end
    i_rst = 1'b1;
    @(negedge clk);
    i_rst = 1'b0;
    for (int k = 0; k < 31; k++) begin
      if (k != 20) begin
        i_addr_log_to_mem = AW'(k);
        @(negedge clk);
        chk("restart_data", o_data_log_from_mem, ext(ref_mem[k]));
      end
    end
    i_addr_log_to_mem = 15'd200;
    @(negedge clk);
    chk("old_capture_kept", o_data_log_from_mem, ext(ref_mem[200]));
    chk("restart_full", 32'(o_mem_full), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
